tt_um_jimktrains_vslc_eeprom_arbiter: RTL and testbench
=======================================================

// Module: tt_um_jimktrains_vslc_eeprom_arbiter
// PURPOSE
//  Shares the single SPI EEPROM byte reader between N_REQ requesters (program fetch, config load, ...).
//  Round-robin grants a burst of 1..16 bytes per request and drives the reader's goto/address/hold lines.
//  Delivers bytes through a 1-entry output buffer with valid/ready handshaking.
//  Skips the reader's instruction/address phase when a burst continues the open stream.
// PARAMETERS
//  N_REQ   2   number of requesters, 2..4
// PORTS
//  clk           in   1        system clock; all logic on posedge
//  rst_n         in   1        synchronous, active-low reset
//  req           in   N_REQ    request per requester; held high until its dout_last is accepted
//  req_addr      in   10*N_REQ start byte address, slot i = [10*i+9:10*i]; stable while req[i]
//  req_len       in   4*N_REQ  burst length minus 1 (0 -> 1 byte, 15 -> 16 bytes)
//  gnt           out  N_REQ    one-hot grant, high from grant until the last byte is accepted
//  dout          out  8        data byte for the granted requester
//  dout_valid    out  1        dout holds an undelivered byte
//  dout_last     out  1        dout is the final byte of the burst
//  dout_ready    in   1        granted requester accepts dout this cycle
//  busy          out  1        burst in progress (state != IDLE)
//  rd_goto       out  1        to reader goto_address; 1-cycle pulse restarts the reader
//  rd_addr       out  10       to reader address; held stable from the rd_goto pulse until the first byte
//  rd_hold_n     out  1        to reader hold_n; low freezes the reader
//  rd_ready      in   1        from reader read_ready
//  rd_byte       in   8        from reader byte_read
// BEHAVIOUR
//  Reset: gnt=0, dout=0, dout_valid=0, dout_last=0, busy=0, rd_goto=0, rd_addr=0, rd_hold_n=1.
//   Reset also sets stream_open=0, rr_ptr=0, cnt=0 and next_addr=0.
//  Reset mid-burst aborts the burst with no further dout_valid.
//  FSM states:
//   IDLE:
//    - rd_hold_n=0 if stream_open, else 1.
//    - If any req: grant the first set req at or after rr_ptr; rr_ptr <= granted+1 mod N_REQ.
//    - Latch addr and len into cnt.
//    - If stream_open && addr==next_addr -> STREAM (no goto); else -> SEEK.
//   SEEK:
//    - rd_addr <= addr; rd_goto=1 for exactly one cycle (first SEEK cycle), rd_hold_n=1.
//    - stream_open <= 1; -> STREAM.
//    - The reader needs >= 24 clk of instruction+address before its first byte.
//   STREAM:
//    - Capture: rd_byte is captured one clk after a rising edge of rd_ready (registered edge detect),
//      so bit 0 written on the same edge is included.
//    - On capture: dout <= byte; dout_valid <= 1; dout_last <= (cnt==0).
//      Also next_addr <= next_addr+1, wrapping 0x3FF -> 0x000.
//    - Accept: dout_valid && dout_ready; dout_valid clears on that cycle unless a new capture lands the same cycle.
//    - cnt decrements on each capture.
//    - When the byte with dout_last is accepted: gnt <= 0 -> IDLE.
//  Backpressure:
//   - Drop rd_hold_n=0 while dout_valid && !dout_ready and the reader's next rd_ready edge is within 1 clk.
//   - Simpler permitted rule: hold whenever dout_valid && !dout_ready.
//   - Release on accept. No byte is ever overwritten or lost.
//  After the last capture:
//   - rd_hold_n <= 0 immediately, freezing the reader mid-next-byte.
//   - Resuming with addr==next_addr delivers the byte at next_addr.
//  Simultaneous events:
//   - A request arriving while busy waits; gnt changes only in IDLE.
//   - req dropped mid-burst is a protocol error; the burst still completes.
//  Latency:
//   - SEEK path: first dout_valid <= 34 clk after the grant.
//   - Continuation: <= 10 clk after the grant.
//   - Following bytes: every 8 clk with no backpressure.
// TESTING (bench uses a behavioural SPI EEPROM plus the real reader)
//  1. req0 addr=0x010 len=3 -> one rd_goto, rd_addr=0x010.
//     4 bytes = mem[0x010..0x013], dout_last on the 4th, gnt0 drops after accept.
//  2. req0 and req1 set in the same cycle, rr_ptr=0 -> req0 burst first, then req1.
//     The next tie goes to req0 again only after req1 is served.
//  3. req0 addr=0x020 len=1, then req1 addr=0x022 len=0 -> second burst has no rd_goto.
//     Its byte = mem[0x022] within 10 clk of the grant.
//  4. dout_ready=0 for 40 clk mid-burst -> rd_hold_n low, dout stable.
//     After release all bytes arrive in order with no duplicates.
//  5. Burst at addr=0x3FE len=3 -> bytes mem[0x3FE], mem[0x3FF], mem[0x000], mem[0x001].
//  6. rst_n low for 1 clk mid-STREAM -> all outputs at reset values next cycle.
//     A new request then issues rd_goto (stream_open cleared).

Source files
------------

// File: rtl/tt_um_jimktrains_vslc_eeprom_arbiter.sv
// Round-robin arbiter sharing one SPI EEPROM byte reader between N_REQ requesters.
// Bytes reach the granted requester through a 1-entry valid/ready buffer.
module tt_um_jimktrains_vslc_eeprom_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [10*N_REQ-1:0] req_addr,
  input  logic [4*N_REQ-1:0]  req_len,
  output logic [N_REQ-1:0]    gnt,
  output logic [7:0]          dout,
  output logic                dout_valid,
  output logic                dout_last,
  input  logic                dout_ready,
  output logic                busy,
  output logic                rd_goto,
  output logic [9:0]          rd_addr,
  output logic                rd_hold_n,
  input  logic                rd_ready,
  input  logic [7:0]          rd_byte
);

  localparam int IW = (N_REQ > 2) ? 2 : 1;
  localparam int CW = IW + 1;
  localparam int AW = 10;
  localparam int LW = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [9:0]       next_addr_q, next_addr_d;
  logic             stream_open_q, stream_open_d;
  logic             last_done_q, last_done_d;
  logic [7:0]       dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             dout_last_q, dout_last_d;
  logic             busy_q, busy_d;
  logic             rd_goto_q, rd_goto_d;
  logic [9:0]       rd_addr_q, rd_addr_d;
  logic             rd_hold_n_q, rd_hold_n_d;
  logic             rd_ready_q;

  logic             pick_found_s;
  logic [IW-1:0]    pick_idx_s;
  logic [IW-1:0]    cand_s;
  logic [9:0]       pick_addr_s;
  logic [3:0]       pick_len_s;
  logic             cont_s;
  logic             capture_s;
  logic             accept_s;
  logic             finish_s;

  function automatic logic [IW-1:0] wrap_idx(input logic [CW-1:0] v);
    logic [IW-1:0] r;
    if (v >= CW'(N_REQ)) begin
      r = IW'(v - CW'(N_REQ));
    end else begin
      r = IW'(v);
    end
    return r;
  endfunction

  // First requester at or after the round-robin pointer wins.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    pick_addr_s  = 10'd0;
    pick_len_s   = 4'd0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = wrap_idx({1'b0, rr_ptr_q} + CW'(k));
      if (!pick_found_s && req[cand_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_s;
        pick_addr_s  = req_addr[AW*int'(cand_s) +: AW];
        pick_len_s   = req_len[LW*int'(cand_s) +: LW];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  assign cont_s    = stream_open_q && (pick_addr_s == next_addr_q);
  // Registered edge detect: the byte is taken one clk after rd_ready rises.
  assign capture_s = (state_q == ST_STREAM) && rd_ready && !rd_ready_q && !last_done_q;
  assign accept_s  = dout_valid_q && dout_ready;
  assign finish_s  = accept_s && dout_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = cont_s ? ST_STREAM : ST_SEEK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEEK:   state_d = ST_STREAM;
      ST_STREAM: begin
        if (finish_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d         = gnt_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    next_addr_d   = next_addr_q;
    stream_open_d = stream_open_q;
    last_done_d   = last_done_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    dout_last_d   = dout_last_q;
    rd_addr_d     = rd_addr_q;
    rd_goto_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          gnt_d       = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          rr_ptr_d    = wrap_idx({1'b0, pick_idx_s} + CW'(1));
          cnt_d       = pick_len_s;
          last_done_d = 1'b0;
          if (!cont_s) begin
            rd_goto_d   = 1'b1;
            rd_addr_d   = pick_addr_s;
            next_addr_d = pick_addr_s;
          end else begin
            rd_goto_d   = 1'b0;
          end
        end else begin
          gnt_d = '0;
        end
      end
      ST_SEEK: begin
        stream_open_d = 1'b1;
      end
      ST_STREAM: begin
        if (capture_s) begin
          dout_d       = rd_byte;
          dout_valid_d = 1'b1;
          dout_last_d  = (cnt_q == 4'd0);
          last_done_d  = (cnt_q == 4'd0);
          next_addr_d  = next_addr_q + 10'd1;
          cnt_d        = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        end else if (accept_s) begin
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
          if (dout_last_q) begin
            gnt_d = '0;
          end else begin
            gnt_d = gnt_q;
          end
        end else begin
          dout_valid_d = dout_valid_q;
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    // Freeze the reader after the final byte and whenever a byte sits unaccepted.
    case (state_d)
      ST_IDLE:   rd_hold_n_d = !stream_open_d;
      ST_SEEK:   rd_hold_n_d = 1'b1;
      ST_STREAM: rd_hold_n_d = !last_done_d && !(dout_valid_q && !dout_ready);
      default:   rd_hold_n_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q         <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= 4'd0;
      next_addr_q   <= 10'd0;
      stream_open_q <= 1'b0;
      last_done_q   <= 1'b0;
      dout_q        <= 8'd0;
      dout_valid_q  <= 1'b0;
      dout_last_q   <= 1'b0;
      busy_q        <= 1'b0;
      rd_goto_q     <= 1'b0;
      rd_addr_q     <= 10'd0;
      rd_hold_n_q   <= 1'b1;
      rd_ready_q    <= 1'b0;
    end else begin
      gnt_q         <= gnt_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      next_addr_q   <= next_addr_d;
      stream_open_q <= stream_open_d;
      last_done_q   <= last_done_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      dout_last_q   <= dout_last_d;
      busy_q        <= busy_d;
      rd_goto_q     <= rd_goto_d;
      rd_addr_q     <= rd_addr_d;
      rd_hold_n_q   <= rd_hold_n_d;
      rd_ready_q    <= rd_ready;
    end
  end

  assign gnt        = gnt_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign busy       = busy_q;
  assign rd_goto    = rd_goto_q;
  assign rd_addr    = rd_addr_q;
  assign rd_hold_n  = rd_hold_n_q;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_eeprom_arbiter.sv
// Directed bench for the EEPROM arbiter, driving it with a behavioural byte-reader model
// (24 clk instruction/address phase, then one byte every 8 clk, frozen while hold_n is low).
module tb_tt_um_jimktrains_vslc_eeprom_arbiter;

  localparam int N_REQ = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [10*N_REQ-1:0] req_addr;
  logic [4*N_REQ-1:0]  req_len;
  logic [N_REQ-1:0]    gnt;
  logic [7:0]          dout;
  logic                dout_valid;
  logic                dout_last;
  logic                dout_ready;
  logic                busy;
  logic                rd_goto;
  logic [9:0]          rd_addr;
  logic                rd_hold_n;
  logic                rd_ready;
  logic [7:0]          rd_byte;

  logic [7:0] mem [0:1023];
  int         n_checks = 0;
  int         n_fail   = 0;

  tt_um_jimktrains_vslc_eeprom_arbiter #(.N_REQ(N_REQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_ready (dout_ready),
    .busy       (busy),
    .rd_goto    (rd_goto),
    .rd_addr    (rd_addr),
    .rd_hold_n  (rd_hold_n),
    .rd_ready   (rd_ready),
    .rd_byte    (rd_byte)
  );

  always #5 clk = ~clk;

  // Reader model: bits 7:1 land one clk before bit 0, which lands with the rd_ready rise.
  logic [9:0] ra;
  int         rc;
  logic       active;
  always @(posedge clk) begin
    if (!rst_n) begin
      active   <= 1'b0;
      rc       <= 0;
      ra       <= 10'd0;
      rd_ready <= 1'b0;
      rd_byte  <= 8'd0;
    end else if (rd_goto) begin
      active   <= 1'b1;
      rc       <= 0;
      ra       <= rd_addr;
      rd_ready <= 1'b0;
    end else if (active && rd_hold_n) begin
      rc <= rc + 1;
      if (rc >= 24) begin
        if ((rc - 23) % 8 == 7) rd_byte[7:1] <= mem[ra][7:1];
        if ((rc - 23) % 8 == 0) begin
          rd_byte[0] <= mem[ra][0];
          rd_ready   <= 1'b1;
          ra         <= ra + 10'd1;
        end else begin
          rd_ready   <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gnt"},        gnt,        32'd0);
    check({tag, "_dout"},       dout,       32'd0);
    check({tag, "_dout_valid"}, dout_valid, 32'd0);
    check({tag, "_dout_last"},  dout_last,  32'd0);
    check({tag, "_busy"},       busy,       32'd0);
    check({tag, "_rd_goto"},    rd_goto,    32'd0);
    check({tag, "_rd_addr"},    rd_addr,    32'd0);
    check({tag, "_rd_hold_n"},  rd_hold_n,  32'd1);
  endtask

  task automatic start_req(input int r, input logic [9:0] a, input logic [3:0] l);
    req_addr[10*r +: 10] = a;
    req_len[4*r +: 4]    = l;
    req[r]               = 1'b1;
  endtask

  // Wait for requester r's grant, collect its burst and release the request.
  task automatic serve(input int r, input logic [9:0] a, input logic [3:0] l, input int exp_goto,
                       input int max_lat, input int stall_at, input int stall_len);
    logic [1:0] oh;
    logic [9:0] ea;
    logic [7:0] held;
    int         t, idx, lat, gotos, stall_left;
    bit         stalled, done;
    oh = 2'b01 << r;
    t  = 0;
    while (!gnt[r] && t < 60) begin
      @(posedge clk); #1; t++;
    end
    check("grant", gnt, oh);
    if (!gnt[r]) begin
      req[r] = 1'b0;
      return;
    end
    check("busy_grant", busy, 1'b1);
    t = 0; idx = 0; lat = -1; gotos = 0; stall_left = 0; stalled = 0; done = 0; held = 8'd0;
    while (!done && t < 600) begin
      if (rd_goto) begin
        gotos++;
        check("rd_addr", rd_addr, a);
      end
      if (stall_left > 0) begin
        check("stall_dout", dout, held);
        stall_left--;
        if (stall_left == 0) begin
          check("stall_hold_n", rd_hold_n, 1'b0);
          check("stall_valid", dout_valid, 1'b1);
          dout_ready = 1'b1;
        end
      end
      if (stall_left == 0 && dout_valid) begin
        if (lat < 0) begin
          lat = t;
          check("latency", (lat <= max_lat), 1'b1);
        end
        if (idx == stall_at && !stalled) begin
          stalled    = 1;
          dout_ready = 1'b0;
          held       = dout;
          stall_left = stall_len;
        end else begin
          ea = a + 10'(idx);
          check("dout_byte", dout, mem[ea]);
          check("dout_last", dout_last, (idx == int'(l)));
          if (idx == int'(l)) begin
            done = 1;
            check("gnt_hold", gnt, oh);
          end
          idx++;
        end
      end
      if (!done) begin
        @(posedge clk); #1; t++;
      end
    end
    check("burst_bytes", idx, int'(l) + 1);
    check("goto_count", gotos, exp_goto);
    @(posedge clk); #1;
    req[r] = 1'b0;
    check("gnt_drop", gnt[r], 1'b0);
    check("busy_end", busy, 1'b0);
    check("valid_end", dout_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen, t;
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 90) ^ (i >> 3));
    rst_n = 1'b0; req = '0; req_addr = '0; req_len = '0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // Tie with rr_ptr=0: req0 first, then req1.
    start_req(0, 10'h100, 4'd1);
    start_req(1, 10'h200, 4'd0);
    serve(0, 10'h100, 4'd1, 1, 34, -1, 0);
    serve(1, 10'h200, 4'd0, 1, 34, -1, 0);
    // Next tie goes to req0 again; req1 then continues the open stream at 0x014.
    start_req(0, 10'h010, 4'd3);
    start_req(1, 10'h014, 4'd0);
    serve(0, 10'h010, 4'd3, 1, 34, -1, 0);
    serve(1, 10'h014, 4'd0, 0, 10, -1, 0);

    // Continuation without rd_goto.
    start_req(0, 10'h020, 4'd1);
    serve(0, 10'h020, 4'd1, 1, 34, -1, 0);
    start_req(1, 10'h022, 4'd0);
    serve(1, 10'h022, 4'd0, 0, 10, -1, 0);

    // Backpressure for 40 clk on the third byte, then continue the stream.
    start_req(0, 10'h030, 4'd5);
    serve(0, 10'h030, 4'd5, 1, 34, 2, 40);
    start_req(1, 10'h036, 4'd1);
    serve(1, 10'h036, 4'd1, 0, 10, -1, 0);

    // Address wrap 0x3FF -> 0x000, and continuation across the wrap.
    start_req(0, 10'h3FE, 4'd3);
    serve(0, 10'h3FE, 4'd3, 1, 34, -1, 0);
    start_req(1, 10'h002, 4'd0);
    serve(1, 10'h002, 4'd0, 0, 10, -1, 0);

    // Reset mid-STREAM.
    start_req(0, 10'h050, 4'd3);
    t = 0;
    while (!dout_valid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("t6_in_stream", {dout_valid, busy}, 2'b11);
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk); #1;
    check_reset("midreset");
    rst_n = 1'b1;
    seen  = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (dout_valid) seen++;
    end
    check("t6_no_valid", seen, 0);
    // next_addr is 0 after reset, but the stream is closed so this must seek.
    start_req(0, 10'h000, 4'd0);
    serve(0, 10'h000, 4'd0, 1, 34, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
